// File: rtl/majority_window_sampler.sv
// ============================================================================
// Module   : majority_window_sampler
// Function : Oversampling front end that gathers N ticked samples of din into
//            a sliding window and delivers a block-wise majority vote over a
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module majority_window_sampler #(
    parameter int N   = 5,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         din,
    output logic [N-1:0] window,
    output logic         vote,
    output logic         vote_valid,
    input  logic         vote_ready,
    output logic         overrun
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FILL_W = (N > 1) ? $clog2(N) : 1;
    localparam int POP_W  = $clog2(N + 1);

    localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [FILL_W-1:0] C_FILL_LAST = FILL_W'(N - 1);
    localparam logic [POP_W-1:0]  C_HALF      = POP_W'(N / 2);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [FILL_W-1:0] r_fill_cnt;
    logic [N-1:0]      r_window;
    logic              r_vote;
    logic              r_vote_valid;
    logic              r_overrun;

    logic              w_tick;
    logic              w_complete;
    logic              w_transfer;
    logic [N-1:0]      w_window_nxt;
    logic [POP_W-1:0]  w_pop;
    logic              w_maj;

    // IDLE/FILL is fully captured by en: dropping en parks both counters at
    // zero, which is what discards a partial block.
    assign w_tick     = en && (r_div_cnt == C_DIV_LAST);
    assign w_complete = w_tick && (r_fill_cnt == C_FILL_LAST);
    assign w_transfer = r_vote_valid && vote_ready;

    generate
        if (N == 1) begin : g_single
            assign w_window_nxt = din;
        end else begin : g_multi
            assign w_window_nxt = {r_window[N-2:0], din};
        end
    endgenerate

    // Vote is taken on the post-shift window so the completing sample counts.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + POP_W'(w_window_nxt[i]);
        end
    end

    assign w_maj = (w_pop > C_HALF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_fill_cnt <= '0;
            r_window   <= '0;
        end else if (!en) begin
            r_div_cnt  <= '0;
            r_fill_cnt <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                r_window   <= w_window_nxt;
                r_fill_cnt <= w_complete ? '0 : r_fill_cnt + 1'b1;
            end
        end
    end

    // A completion always loads; overrun only when the old result is
    // still pending and not being taken this very cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vote       <= 1'b0;
            r_vote_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_complete) begin
            r_vote       <= w_maj;
            r_vote_valid <= 1'b1;
            if (r_vote_valid && !vote_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (w_transfer) begin
            r_vote_valid <= 1'b0;
        end
    end

    assign window     = r_window;
    assign vote       = r_vote;
    assign vote_valid = r_vote_valid;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: doc/majority_window_sampler.md
# majority_window_sampler

Front-end stage for the N-bit majority voter. It samples a noisy serial input `din` at a programmable rate and collects N consecutive samples into a window. The window is exported for the combinational voter. The block also registers its own block-wise majority decision and delivers it through a valid/ready handshake. Typical use is as a deglitch/oversampling filter ahead of control logic.

## Interface
- `N`, default 5: window size in samples; legal range N ≥ 1.
- `DIV`, default 4: clock cycles per sample tick; legal range DIV ≥ 1.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low: state is cleared on a rising edge of `clk` where `rst_n` = 0.
- `en`  in  1  sampling enable.
- `din`  in  1  raw serial input, sampled on tick cycles only.
- `window`  out  N  the last N samples; bit 0 is the newest. Intended to feed the majority voter's `a` input.
- `vote`  out  1  registered majority of the most recently completed block.
- `vote_valid`  out  1  `vote` holds an undelivered result.
- `vote_ready`  in  1  consumer accepts `vote` in any cycle where `vote_valid` && `vote_ready`.
- `overrun`  out  1  sticky flag: an undelivered result was overwritten.

## Operation
- **Tick generator:** counter `div_cnt`, width clog2(DIV), minimum 1.
  - While `en` = 1, `div_cnt` counts 0..DIV-1 and wraps.
  - `tick` = `en` && (`div_cnt` == DIV-1).
  - For DIV = 1, every enabled cycle is a tick.
- **Shift on tick:** `window` <= {`window`[N-2:0], `din`}. For N = 1, `window` <= `din`.
- **Fill counter:** `fill_cnt` counts 0..N-1.
  - On a tick with `fill_cnt` == N-1, the block is complete:
    - `fill_cnt` <= 0;
    - `vote` <= (popcount of the post-shift window > N/2, integer division);
    - `vote_valid` <= 1.
  - On any other tick, `fill_cnt` increments.
- **Majority rule:** must match the voter exactly: strictly greater than floor(N/2). For even N, a tie gives 0 (e.g. N = 4, two ones → 0).
- **Popcount width:** clog2(N+1) bits, no overflow.
- **Blocks are non-overlapping:** after a completion, the next vote uses N fresh samples. `window` itself slides continuously on every tick.
- **States:**
  - IDLE (`en` = 0): `div_cnt` and `fill_cnt` held at 0; `window` retains its contents.
  - FILL (`en` = 1): counting and shifting as above.
  - IDLE→FILL when `en` rises; FILL→IDLE when `en` falls.
  - A partial block is discarded on FILL→IDLE.
  - `vote`, `vote_valid` and `overrun` are unaffected by `en`; a pending result remains deliverable.
- **Handshake:**
  - `vote_valid` stays 1 and `vote` stays stable until a transfer cycle (`vote_valid` && `vote_ready`). `vote_valid` clears after that cycle unless a completion occurs in the same cycle.
  - Completion and transfer in the same cycle: the old value is transferred, the new value is loaded, `vote_valid` stays 1, and `overrun` does not set.
  - Completion while `vote_valid` = 1 and `vote_ready` = 0: `vote` is overwritten with the new result and `overrun` <= 1. `overrun` clears only on reset.
  - `vote_ready` with `vote_valid` = 0 has no effect.

## Timing
- **Reset:** while `rst_n` = 0 at an edge, the following are cleared to 0 at that edge: `window`, `vote`, `vote_valid`, `overrun`, `div_cnt`, `fill_cnt`.
- **Reset dominates:** it takes priority over `en`, `tick` and `vote_ready` in the same cycle. A reset mid-block discards the partial block and any pending result.
- **Tick timing:** let cycle 0 be the first edge with `en` = 1 after IDLE. Ticks occur at cycles DIV-1, 2·DIV-1, …
- **First vote:** `vote_valid` rises after the edge of cycle N·DIV-1, so it is first visible in cycle N·DIV. This is 20 cycles for the defaults.
- **Sustained throughput:** one result per N·DIV cycles.
- **Window update:** `window` changes only on the edge of a tick cycle, so the downstream voter output is valid one cycle after each tick.
- **Registered outputs:** all outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
1. **Reset:** hold `rst_n` = 0 for 3 cycles with `en` = 1 and `din` toggling → `window` = 0, `vote` = 0, `vote_valid` = 0, `overrun` = 0 throughout; counting begins on the first cycle after release.
2. **Majority 1:** N = 5, DIV = 4, `en` = 1, `vote_ready` = 1. Present `din` = 1,1,0,1,0 at ticks 1–5 → `window` = 5'b11010, `vote` = 1. `vote_valid` = 1 in cycle 20 only, because it is accepted immediately.
3. **Majority 0:** samples 0,0,1,0,1 → `vote` = 0, `vote_valid` pulses. Also check N = 4 with samples 1,1,0,0 → `vote` = 0 (tie).
4. **Overrun:** `vote_ready` = 0 across two blocks, with the first block's samples all 1 and the second's all 0 → after block 2, `vote` = 0, `vote_valid` = 1, `overrun` = 1. Then raise `vote_ready` for 1 cycle → `vote_valid` = 0 and `overrun` stays 1.
5. **Enable drop mid-block:** drop `en` after 3 ticks for 5 cycles, then raise it → no vote from the partial block. The next `vote_valid` comes 20 cycles after re-enable and reflects the 5 new samples.
6. **Simultaneous completion and accept:** hold `vote_valid` = 1 and assert `vote_ready` in the completion cycle → the old `vote` is accepted, the new `vote` is loaded, `vote_valid` stays 1, and `overrun` stays 0.
